// File: rtl/pipeline_ctrl.sv
// Central pipeline controller: stage stall vector, exception/ERET flush sequencing,
// data-bus wait-state watchdog and saturating stall-cycle counter.
module pipeline_ctrl #(
  parameter logic [31:0] EXC_ENTRY = 32'hBFC00380,
  parameter int          TIMEOUT   = 255,
  parameter int          CNT_W     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        excp_valid,
  input  logic        excp_is_eret,
  input  logic [31:0] cp0_epc,
  input  logic        perf_clr,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        bus_timeout,
  output logic [31:0] stall_cycles
);

  typedef enum logic {RUN, MASK} state_t;

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [5:0]       stall_req;
  logic [CNT_W-1:0] wd_cnt;

  // Highest requesting stage wins; everything upstream of it holds too.
  always_comb begin
    stall_req = 6'b000000;
    if (stallreq_mem)     stall_req = 6'b011111;
    else if (stallreq_ex) stall_req = 6'b001111;
    else if (stallreq_id) stall_req = 6'b000111;
    else if (stallreq_if) stall_req = 6'b000011;
  end

  // MASK only ever lasts one cycle, so the default next state is RUN.
  always_comb begin
    state_d = RUN;
    stall   = stall_req;
    flush   = 1'b0;
    new_pc  = 32'h0;
    if (rst) begin
      stall = 6'b000000;
    end else if (state_q == RUN && excp_valid && !stallreq_mem) begin
      flush   = 1'b1;
      stall   = 6'b000000;
      new_pc  = excp_is_eret ? cp0_epc : EXC_ENTRY;
      state_d = MASK;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Watchdog re-arms after each pulse so a persistent stall pulses every TIMEOUT cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt      <= '0;
      bus_timeout <= 1'b0;
    end else if (!stallreq_mem || flush) begin
      wd_cnt      <= '0;
      bus_timeout <= 1'b0;
    end else if (wd_cnt == WD_LAST) begin
      wd_cnt      <= '0;
      bus_timeout <= 1'b1;
    end else begin
      wd_cnt      <= wd_cnt + 1'b1;
      bus_timeout <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cycles <= 32'h0;
    else if (perf_clr)
      stall_cycles <= 32'h0;
    else if (stall[0] && stall_cycles != 32'hFFFFFFFF)
      stall_cycles <= stall_cycles + 32'h1;
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios plus random traffic, every cycle
// compared against a behavioural model of the controller's rules.
module tb_pipeline_ctrl;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallreq_if = 0, stallreq_id = 0, stallreq_ex = 0, stallreq_mem = 0;
  logic        excp_valid = 0, excp_is_eret = 0, perf_clr = 0;
  logic [31:0] cp0_epc = 32'h0;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        bus_timeout;
  logic [31:0] stall_cycles;

  int passed = 0;
  int total  = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  pipeline_ctrl #(.EXC_ENTRY(32'hBFC00380), .TIMEOUT(T), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .excp_valid(excp_valid), .excp_is_eret(excp_is_eret),
    .cp0_epc(cp0_epc), .perf_clr(perf_clr),
    .stall(stall), .flush(flush), .new_pc(new_pc),
    .bus_timeout(bus_timeout), .stall_cycles(stall_cycles)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    else passed++;
  endtask

  // ---------------- behavioural model ----------------
  // m_masked: previous cycle was a flush. m_run: consecutive bus-wait cycles.
  logic        m_masked = 1'b0;
  int          m_run    = 0;
  logic        m_bt     = 1'b0;
  logic [31:0] m_sc     = 32'h0;

  always @(negedge clk) begin
    logic        acc;
    logic [5:0]  es;
    logic [31:0] ep;
    acc = !rst && excp_valid && !stallreq_mem && !m_masked;
    if (rst || acc)        es = 6'd0;
    else if (stallreq_mem) es = 6'b011111;
    else if (stallreq_ex)  es = 6'b001111;
    else if (stallreq_id)  es = 6'b000111;
    else if (stallreq_if)  es = 6'b000011;
    else                   es = 6'd0;
    ep = acc ? (excp_is_eret ? cp0_epc : 32'hBFC00380) : 32'h0;
    chk("m_stall", {26'd0, stall}, {26'd0, es});
    chk("m_flush", {31'd0, flush}, {31'd0, acc});
    chk("m_new_pc", new_pc, ep);
    chk("m_bus_timeout", {31'd0, bus_timeout}, rst ? 32'd0 : {31'd0, m_bt});
    chk("m_stall_cycles", stall_cycles, rst ? 32'd0 : m_sc);
    if (rst) begin
      m_masked = 1'b0; m_run = 0; m_bt = 1'b0; m_sc = 32'h0;
    end else begin
      m_masked = acc;
      if (stallreq_mem) begin
        m_run++;
        m_bt = (m_run % T == 0);
      end else begin
        m_run = 0;
        m_bt  = 1'b0;
      end
      if (perf_clr)                          m_sc = 32'h0;
      else if (es[0] && m_sc != 32'hFFFFFFFF) m_sc = m_sc + 32'h1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic nxt();
    @(posedge clk); #1;
    stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
    excp_valid = 0; excp_is_eret = 0; perf_clr = 0;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    settle();
    chk("reset_stall", {26'd0, stall}, 32'd0);
    chk("reset_flush", {31'd0, flush}, 32'd0);
    chk("reset_sc", stall_cycles, 32'd0);
    nxt(); rst = 0;

    // priority ladder
    nxt(); {stallreq_if, stallreq_id, stallreq_ex, stallreq_mem} = 4'b1111; settle();
    chk("prio_mem", {26'd0, stall}, 32'h1F);
    nxt(); {stallreq_if, stallreq_id, stallreq_ex} = 3'b111; settle();
    chk("prio_ex", {26'd0, stall}, 32'h0F);
    nxt(); {stallreq_if, stallreq_id} = 2'b11; settle();
    chk("prio_id", {26'd0, stall}, 32'h07);
    nxt(); stallreq_if = 1; settle();
    chk("prio_if", {26'd0, stall}, 32'h03);

    // exception overriding ex stall, then masked repeat
    nxt(); excp_valid = 1; stallreq_ex = 1; settle();
    chk("exc_flush", {31'd0, flush}, 32'd1);
    chk("exc_pc", new_pc, 32'hBFC00380);
    chk("exc_stall", {26'd0, stall}, 32'd0);
    nxt(); excp_valid = 1; stallreq_ex = 1; settle();
    chk("mask_flush", {31'd0, flush}, 32'd0);
    chk("mask_stall", {26'd0, stall}, 32'h0F);
    nxt();

    // ERET deferred by data-bus wait
    cp0_epc = 32'h80001234;
    for (int k = 0; k < 3; k++) begin
      nxt(); excp_valid = 1; excp_is_eret = 1; stallreq_mem = 1; settle();
      chk("eret_defer_flush", {31'd0, flush}, 32'd0);
      chk("eret_defer_stall", {26'd0, stall}, 32'h1F);
    end
    nxt(); excp_valid = 1; excp_is_eret = 1; settle();
    chk("eret_flush", {31'd0, flush}, 32'd1);
    chk("eret_pc", new_pc, 32'h80001234);
    nxt();

    // watchdog: persistent stall pulses in cycles 5 and 9
    for (int k = 1; k <= 9; k++) begin
      nxt(); stallreq_mem = 1; settle();
      chk("wd_run", {31'd0, bus_timeout}, (k == 5 || k == 9) ? 32'd1 : 32'd0);
    end
    nxt(); settle();
    chk("wd_idle", {31'd0, bus_timeout}, 32'd0);
    for (int k = 0; k < 3; k++) begin nxt(); stallreq_mem = 1; end
    nxt(); settle();
    chk("wd_short", {31'd0, bus_timeout}, 32'd0);
    for (int k = 1; k <= 5; k++) begin
      nxt(); stallreq_mem = (k <= 4); settle();
      chk("wd_rearm", {31'd0, bus_timeout}, (k == 5) ? 32'd1 : 32'd0);
    end

    // perf counter
    nxt(); perf_clr = 1;
    for (int k = 0; k < 10; k++) begin nxt(); stallreq_id = 1; end
    nxt(); settle();
    chk("perf_10", stall_cycles, 32'd10);
    nxt(); stallreq_id = 1; perf_clr = 1;
    nxt(); settle();
    chk("perf_clr_stall", stall_cycles, 32'd0);
    nxt(); dut.stall_cycles = 32'hFFFFFFFD; m_sc = 32'hFFFFFFFD;
    for (int k = 0; k < 5; k++) begin nxt(); stallreq_id = 1; end
    nxt(); settle();
    chk("perf_sat", stall_cycles, 32'hFFFFFFFF);
    nxt(); stallreq_id = 1; perf_clr = 1;
    nxt(); settle();
    chk("perf_clr_sat", stall_cycles, 32'd0);

    // async reset while in MASK with a stall pending
    nxt(); stallreq_id = 1;
    nxt(); excp_valid = 1; stallreq_ex = 1;
    nxt(); excp_valid = 1; stallreq_ex = 1; stallreq_mem = 1;
    #1 rst = 1; #1;
    chk("arst_stall", {26'd0, stall}, 32'd0);
    chk("arst_flush", {31'd0, flush}, 32'd0);
    chk("arst_bt", {31'd0, bus_timeout}, 32'd0);
    chk("arst_sc", stall_cycles, 32'd0);
    nxt(); rst = 0; excp_valid = 1; stallreq_ex = 1; settle();
    chk("arst_exc_flush", {31'd0, flush}, 32'd1);
    chk("arst_exc_pc", new_pc, 32'hBFC00380);

    // random traffic with bursty bus waits
    for (int k = 0; k < 2000; k++) begin
      logic mem_prev;
      mem_prev = stallreq_mem;
      nxt();
      stallreq_if  = ($urandom_range(0, 3) == 0);
      stallreq_id  = ($urandom_range(0, 4) == 0);
      stallreq_ex  = ($urandom_range(0, 4) == 0);
      stallreq_mem = mem_prev ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 7) == 0);
      excp_valid   = ($urandom_range(0, 5) == 0);
      excp_is_eret = $urandom_range(0, 1);
      cp0_epc      = $urandom;
      perf_clr     = ($urandom_range(0, 39) == 0);
      rst          = ($urandom_range(0, 149) == 0);
    end
    nxt(); rst = 0;
    settle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central pipeline controller for the five-stage MIPS core. It turns per-stage stall requests into the 6-bit stall vector consumed by the PC and every inter-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB). It also sequences exception and ERET flushes, supplying the redirect PC. It adds a data-bus wait-state watchdog and a saturating stall-cycle performance counter for CP0.

## Interface
Parameters:
- EXC_ENTRY, 32'hBFC00380, exception vector loaded into PC on exception flush
- TIMEOUT, 255, consecutive stallreq_mem cycles before bus_timeout fires (1..2^CNT_W-1)
- CNT_W, 8, watchdog counter width

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- stallreq_if  in  1  fetch bus not ready
- stallreq_id  in  1  load-use hazard in decode
- stallreq_ex  in  1  multi-cycle mult/div busy
- stallreq_mem  in  1  data bus not ready
- excp_valid  in  1  exception/ERET committed at MEM stage
- excp_is_eret  in  1  qualifies excp_valid: 1 = ERET, 0 = exception
- cp0_epc  in  32  return address for ERET
- perf_clr  in  1  synchronous clear of stall_cycles
- stall  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = hold
- flush  out  1  clear all inter-stage registers this cycle
- new_pc  out  32  redirect target, valid only while flush=1, else 0
- bus_timeout  out  1  registered one-cycle pulse to CP0
- stall_cycles  out  32  count of cycles with stall[0]=1

## Operation
- Stall vector is combinational, and the highest requesting stage wins. Priority order:
  - stallreq_mem gives 6'b011111
  - else stallreq_ex gives 6'b001111
  - else stallreq_id gives 6'b000111
  - else stallreq_if gives 6'b000011
  - else 6'b000000
- Each inter-stage register inserts a bubble when its own stage is stalled and the next stage is not.
- The FSM has two states, RUN and MASK.
- RUN:
  - Exception acceptance is acc = excp_valid & ~stallreq_mem.
  - When acc=1:
    - flush=1 and stall=6'b000000 in that same cycle.
    - new_pc = cp0_epc if excp_is_eret, else EXC_ENTRY.
    - Next state is MASK.
  - When excp_valid=1 and stallreq_mem=1, acceptance is deferred. The normal stall vector applies until the data bus completes.
- MASK:
  - Lasts exactly one cycle, then returns to RUN.
  - excp_valid is ignored, because it is stale from flushed registers.
  - flush=0 and the stall vector follows requests normally.
- Watchdog:
  - wd_cnt (CNT_W bits) increments each cycle stallreq_mem=1 and clears to 0 whenever stallreq_mem=0 or flush=1.
  - When wd_cnt==TIMEOUT-1 and stallreq_mem=1, the controller registers bus_timeout=1 for the next cycle and clears wd_cnt.
  - If the stall persists, the watchdog re-arms and pulses again every TIMEOUT cycles.
- Perf counter:
  - Update priority is perf_clr first: perf_clr=1 loads 0.
  - Otherwise stall_cycles increments when stall[0]=1.
  - It saturates at 32'hFFFFFFFF.
  - A flush cycle does not count, because stall=0 in that cycle.

## Timing
- stall, flush and new_pc are combinational from inputs and state, with zero latency. The consuming registers act on the same rising edge.
- bus_timeout has 1-cycle latency: it is high in the cycle after the TIMEOUT-th consecutive stallreq_mem cycle.
- stall_cycles reflects a stalled cycle on the following edge.
- Reset, asynchronous, at any time including mid-stall or the MASK state:
  - state=RUN, wd_cnt=0, bus_timeout=0, stall_cycles=0.
  - While rst=1, stall=0, flush=0 and new_pc=0 regardless of inputs.
- Simultaneous events:
  - An accepted exception overrides stallreq_if, stallreq_id and stallreq_ex in the same cycle.
  - excp_valid with stallreq_mem never flushes.
  - perf_clr together with stall[0]=1 results in 0.
  - perf_clr at saturation results in 0.
- Back-to-back excp_valid on consecutive cycles produces exactly one flush.

## Test plan
- Priority: stallreq_if=stallreq_id=stallreq_ex=stallreq_mem=1 gives stall=6'b011111. Drop stallreq_mem and stall=6'b001111. Drop stallreq_ex and stall=6'b000111. Drop stallreq_id and stall=6'b000011.
- Exception: excp_valid=1, excp_is_eret=0, stallreq_ex=1 gives flush=1, new_pc=32'hBFC00380, stall=0 for one cycle. Holding excp_valid=1 the next cycle gives flush=0 (MASK).
- ERET deferred: cp0_epc=32'h80001234, excp_valid=1, stallreq_mem=1 for 3 cycles gives no flush and stall=6'b011111. The cycle stallreq_mem falls, flush=1 and new_pc=32'h80001234.
- Watchdog with TIMEOUT=4: stallreq_mem high for 9 cycles gives bus_timeout pulses in cycles 5 and 9 only. Dropping stallreq_mem after 3 cycles and re-raising gives no pulse until 4 new cycles have elapsed.
- Perf counter: stallreq_id high 10 cycles gives stall_cycles=10. perf_clr with stall gives 0. Preload near saturation and check it holds at 32'hFFFFFFFF.
- Async reset: assert rst mid-stall in MASK state. Immediately stall=0, flush=0 and bus_timeout=0, with stall_cycles=0. After release, state is RUN and a fresh exception flushes.
